// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: canonical NOP encoding and the fetch responder FSM states.
package riscv_pkg;

   typedef logic [31:0] word_t;

   localparam word_t RV_NOP_INSTR = 32'h0000_0013;

   localparam logic [0:0] FETCH_IDLE = 1'b0;
   localparam logic [0:0] FETCH_REQ  = 1'b1;

   function automatic logic is_misaligned(input logic [1:0] byte_off);
      return byte_off != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_bus_responder.sv
// Instruction-port responder: serves fetch_address from a one-entry buffer and
// refills it over a single-outstanding req/ack memory bus.
module fetch_bus_responder
   import riscv_pkg::*;
#(
   parameter word_t NOP_INSTR = RV_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] fetch_address,
   input  logic        flush,
   output logic [31:0] fetch_data,
   output logic        fetch_stall,
   output logic        fetch_fault,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err
);

   logic [0:0] state_q, state_d;
   logic       buf_valid_q, buf_valid_d;
   word_t      buf_addr_q, buf_addr_d;
   word_t      buf_data_q, buf_data_d;
   logic       buf_err_q, buf_err_d;
   logic       discard_q, discard_d;
   logic       mem_req_q, mem_req_d;
   word_t      mem_addr_q, mem_addr_d;

   logic misaligned;
   logic hit;

   always_comb begin
      misaligned = is_misaligned(fetch_address[1:0]);
      // A flush in the same cycle already invalidates the entry for lookup.
      hit        = buf_valid_q && (buf_addr_q == fetch_address) && !flush;
   end

   always_comb begin
      fetch_stall = 1'b1;
      fetch_fault = 1'b0;
      fetch_data  = NOP_INSTR;
      if (!reset) begin
         if (misaligned) begin
            fetch_stall = 1'b0;
            fetch_fault = 1'b1;
         end else if (hit) begin
            fetch_stall = 1'b0;
            fetch_fault = buf_err_q;
            if (!buf_err_q) begin
               fetch_data = buf_data_q;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      buf_err_d   = buf_err_q;
      discard_d   = discard_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;

      case (state_q)
         FETCH_IDLE: begin
            if (!hit && !misaligned && !flush) begin
               state_d    = FETCH_REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_address;
            end
         end
         FETCH_REQ: begin
            // A redirect never aborts the bus; the old word still lands in the buffer.
            if (mem_ack) begin
               state_d   = FETCH_IDLE;
               mem_req_d = 1'b0;
               discard_d = 1'b0;
               if (!discard_q && !flush) begin
                  buf_valid_d = 1'b1;
                  buf_addr_d  = mem_addr_q;
                  buf_data_d  = mem_rdata;
                  buf_err_d   = mem_err;
               end
            end else if (flush) begin
               discard_d = 1'b1;
            end
         end
         default: begin
            state_d   = FETCH_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      if (flush) begin
         buf_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FETCH_IDLE;
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_err_q   <= 1'b0;
         discard_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_err_q   <= buf_err_d;
         discard_q   <= discard_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   // Instruction word storage is only meaningful behind buf_valid_q, so it carries no reset.
   always_ff @(posedge clk) begin
      buf_data_q <= buf_data_d;
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_fetch_bus_responder.sv
// Self-checking bench for fetch_bus_responder: directed scenarios plus a randomized
// run against a transaction-level reference of the buffer and bus.
module tb_fetch_bus_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic [31:0] fetch_address;
   logic        flush;
   logic [31:0] fetch_data;
   logic        fetch_stall;
   logic        fetch_fault;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_err;

   int vectors;
   int miscompares;
   logic [31:0] pool [0:6];

   fetch_bus_responder dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_address (fetch_address),
      .flush         (flush),
      .fetch_data    (fetch_data),
      .fetch_stall   (fetch_stall),
      .fetch_fault   (fetch_fault),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .mem_err       (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] gword(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   function automatic logic gerr(input logic [31:0] a);
      return a[7:4] == 4'h1;
   endfunction

   task automatic drive(input logic [31:0] fa, input logic fl, input logic ack,
                        input logic [31:0] rd, input logic er);
      fetch_address = fa;
      flush         = fl;
      mem_ack       = ack;
      mem_rdata     = rd;
      mem_err       = er;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      next_cycle();
      next_cycle();
      #4;
      vectors++;
      if ({fetch_stall, fetch_fault, fetch_data} !== {1'b1, 1'b0, NOP}) begin
         miscompares++;
         $display("FAIL reset_outputs got %h want %h", {fetch_stall, fetch_fault, fetch_data}, {1'b1, 1'b0, NOP});
      end
      vectors++;
      if ({mem_req, mem_addr} !== 33'h0) begin
         miscompares++;
         $display("FAIL reset_bus got %h want %h", {mem_req, mem_addr}, 33'h0);
      end
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_fill();
      #4;
      vectors++;
      if ({fetch_stall, mem_req} !== 2'b10) begin
         miscompares++;
         $display("FAIL fill_first_cycle stall/req got %b want %b", {fetch_stall, mem_req}, 2'b10);
      end
      next_cycle();
      #4;
      vectors++;
      if ({fetch_stall, mem_req, mem_addr} !== {2'b11, 32'h8000_0000}) begin
         miscompares++;
         $display("FAIL fill_req got %h want %h", {fetch_stall, mem_req, mem_addr}, {2'b11, 32'h8000_0000});
      end
      next_cycle();
      #4;
      vectors++;
      if (fetch_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_wait stall got %b want 1", fetch_stall);
      end
      next_cycle();
      drive(32'h8000_0000, 1'b0, 1'b1, 32'h0000_0297, 1'b0);
      #4;
      vectors++;
      if (fetch_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_ack_cycle stall got %b want 1", fetch_stall);
      end
      next_cycle();
      drive(32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, fetch_fault, mem_req, fetch_data} !== {3'b000, 32'h0000_0297}) begin
         miscompares++;
         $display("FAIL fill_done got %h want %h", {fetch_stall, fetch_fault, mem_req, fetch_data}, {3'b000, 32'h0000_0297});
      end
      next_cycle();
   endtask

   task automatic test_hold();
      int extra_req;
      int stalled;
      extra_req = 0;
      stalled   = 0;
      for (int i = 0; i < 10; i++) begin
         #4;
         if (mem_req === 1'b1) extra_req++;
         if (fetch_stall !== 1'b0 || fetch_data !== 32'h0000_0297) stalled++;
         next_cycle();
      end
      vectors++;
      if (extra_req != 0) begin
         miscompares++;
         $display("FAIL hold_no_req cycles_with_req got %0d want 0", extra_req);
      end
      vectors++;
      if (stalled != 0) begin
         miscompares++;
         $display("FAIL hold_hit bad_cycles got %0d want 0", stalled);
      end
   endtask

   task automatic test_misaligned();
      for (int i = 0; i < 3; i++) begin
         drive(32'h8000_0002 + 32'(i % 2), 1'b0, 1'b0, 32'h0, 1'b0);
         #4;
         vectors++;
         if ({fetch_stall, fetch_fault, mem_req, fetch_data} !== {3'b010, NOP}) begin
            miscompares++;
            $display("FAIL misaligned got %h want %h", {fetch_stall, fetch_fault, mem_req, fetch_data}, {3'b010, NOP});
         end
         next_cycle();
      end
   endtask

   task automatic test_bus_error();
      drive(32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if (fetch_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL err_miss stall got %b want 1", fetch_stall);
      end
      next_cycle();
      drive(32'h8000_0010, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      #4;
      vectors++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h8000_0010}) begin
         miscompares++;
         $display("FAIL err_req got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h8000_0010});
      end
      next_cycle();
      drive(32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, fetch_fault, fetch_data} !== {2'b01, NOP}) begin
         miscompares++;
         $display("FAIL err_fault got %h want %h", {fetch_stall, fetch_fault, fetch_data}, {2'b01, NOP});
      end
      next_cycle();
      drive(32'h8000_0012, 1'b0, 1'b0, 32'h0, 1'b0);
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         drive(32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
         #4;
         vectors++;
         if ({fetch_stall, fetch_fault, mem_req, fetch_data} !== {3'b010, NOP}) begin
            miscompares++;
            $display("FAIL err_cached got %h want %h", {fetch_stall, fetch_fault, mem_req, fetch_data}, {3'b010, NOP});
         end
         next_cycle();
      end
   endtask

   task automatic test_redirect();
      logic [31:0] r1;
      logic [31:0] r2;
      r1 = $urandom;
      r2 = $urandom | 32'h1;
      drive(32'h8000_0004, 1'b0, 1'b0, 32'h0, 1'b0);
      next_cycle();
      drive(32'h8000_0100, 1'b0, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, mem_req, mem_addr} !== {2'b11, 32'h8000_0004}) begin
         miscompares++;
         $display("FAIL redir_first_req got %h want %h", {fetch_stall, mem_req, mem_addr}, {2'b11, 32'h8000_0004});
      end
      next_cycle();
      drive(32'h8000_0100, 1'b0, 1'b1, r1, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, mem_addr} !== {1'b1, 32'h8000_0004}) begin
         miscompares++;
         $display("FAIL redir_addr_stable got %h want %h", {fetch_stall, mem_addr}, {1'b1, 32'h8000_0004});
      end
      next_cycle();
      drive(32'h8000_0100, 1'b0, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, mem_req} !== 2'b10) begin
         miscompares++;
         $display("FAIL redir_gap got %b want %b", {fetch_stall, mem_req}, 2'b10);
      end
      next_cycle();
      drive(32'h8000_0100, 1'b0, 1'b1, r2, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, mem_req, mem_addr} !== {2'b11, 32'h8000_0100}) begin
         miscompares++;
         $display("FAIL redir_second_req got %h want %h", {fetch_stall, mem_req, mem_addr}, {2'b11, 32'h8000_0100});
      end
      next_cycle();
      drive(32'h8000_0100, 1'b0, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, fetch_fault, fetch_data} !== {2'b00, r2}) begin
         miscompares++;
         $display("FAIL redir_data got %h want %h", {fetch_stall, fetch_fault, fetch_data}, {2'b00, r2});
      end
      next_cycle();
   endtask

   task automatic test_flush();
      logic [31:0] rd;
      rd = $urandom;
      drive(32'h8000_0200, 1'b0, 1'b0, 32'h0, 1'b0);
      next_cycle();
      drive(32'h8000_0200, 1'b1, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, mem_req} !== 2'b11) begin
         miscompares++;
         $display("FAIL flush_in_req got %b want %b", {fetch_stall, mem_req}, 2'b11);
      end
      next_cycle();
      drive(32'h8000_0200, 1'b0, 1'b1, rd, 1'b0);
      next_cycle();
      drive(32'h8000_0200, 1'b0, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, mem_req, fetch_data} !== {2'b10, NOP}) begin
         miscompares++;
         $display("FAIL flush_dropped got %h want %h", {fetch_stall, mem_req, fetch_data}, {2'b10, NOP});
      end
      next_cycle();
      drive(32'h8000_0200, 1'b1, 1'b1, rd, 1'b0);
      #4;
      vectors++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h8000_0200}) begin
         miscompares++;
         $display("FAIL flush_rereq got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h8000_0200});
      end
      next_cycle();
      drive(32'h8000_0200, 1'b0, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, mem_req} !== 2'b10) begin
         miscompares++;
         $display("FAIL flush_with_ack got %b want %b", {fetch_stall, mem_req}, 2'b10);
      end
      next_cycle();
      drive(32'h8000_0200, 1'b0, 1'b1, rd, 1'b0);
      next_cycle();
      drive(32'h8000_0200, 1'b0, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, fetch_data} !== {1'b0, rd}) begin
         miscompares++;
         $display("FAIL flush_final_fill got %h want %h", {fetch_stall, fetch_data}, {1'b0, rd});
      end
      next_cycle();
      drive(32'h8000_0200, 1'b1, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, fetch_data} !== {1'b1, NOP}) begin
         miscompares++;
         $display("FAIL flush_on_hit got %h want %h", {fetch_stall, fetch_data}, {1'b1, NOP});
      end
      next_cycle();
      drive(32'h8000_0200, 1'b0, 1'b0, 32'h0, 1'b0);
      #4;
      vectors++;
      if ({fetch_stall, mem_req} !== 2'b10) begin
         miscompares++;
         $display("FAIL flush_invalidated got %b want %b", {fetch_stall, mem_req}, 2'b10);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_req();
      #4;
      vectors++;
      if (mem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_pre req got %b want 1", mem_req);
      end
      reset = 1'b1;
      next_cycle();
      #4;
      vectors++;
      if ({mem_req, mem_addr, fetch_stall, fetch_fault, fetch_data} !== {33'h0, 2'b10, NOP}) begin
         miscompares++;
         $display("FAIL midreset got %h want %h", {mem_req, mem_addr, fetch_stall, fetch_fault, fetch_data}, {33'h0, 2'b10, NOP});
      end
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_random();
      logic        m_valid, m_err, m_req, m_disc;
      logic [31:0] m_addr, m_data, m_maddr;
      logic [31:0] fa;
      logic        fl, ack, hit, mis;
      logic [33:0] exp_out;
      int          lat;
      m_valid = 1'b0; m_err = 1'b0; m_req = 1'b0; m_disc = 1'b0;
      m_addr = '0; m_data = '0; m_maddr = '0; lat = 0;
      fa = pool[0];
      reset = 1'b1;
      drive(fa, 1'b0, 1'b0, 32'h0, 1'b0);
      next_cycle();
      reset = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 3) == 0) fa = pool[$urandom_range(0, 6)];
         fl  = ($urandom_range(0, 15) == 0);
         ack = m_req && (lat == 0);
         if (m_req && lat != 0) lat--;
         if (ack) drive(fa, fl, 1'b1, gword(m_maddr), gerr(m_maddr));
         else     drive(fa, fl, 1'b0, $urandom, 1'($urandom_range(0, 1)));
         mis = (fa[1:0] != 2'b00);
         hit = m_valid && (m_addr == fa) && !fl;
         if (mis)      exp_out = {2'b01, NOP};
         else if (hit) exp_out = {1'b0, m_err, m_err ? NOP : m_data};
         else          exp_out = {2'b10, NOP};
         #4;
         vectors++;
         if ({fetch_stall, fetch_fault, fetch_data} !== exp_out) begin
            miscompares++;
            $display("FAIL rand_out cyc %0d addr %h got %h want %h", cyc, fa, {fetch_stall, fetch_fault, fetch_data}, exp_out);
         end
         vectors++;
         if (mem_req !== m_req || (m_req && mem_addr !== m_maddr)) begin
            miscompares++;
            $display("FAIL rand_bus cyc %0d got %b/%h want %b/%h", cyc, mem_req, mem_addr, m_req, m_maddr);
         end
         @(posedge clk);
         if (!m_req) begin
            if (!hit && !mis && !fl) begin
               m_req   = 1'b1;
               m_maddr = fa;
               lat     = $urandom_range(0, 3);
            end
         end else if (ack) begin
            m_req = 1'b0;
            if (!m_disc && !fl) begin
               m_valid = 1'b1;
               m_addr  = m_maddr;
               m_data  = gword(m_maddr);
               m_err   = gerr(m_maddr);
            end
            m_disc = 1'b0;
         end else if (fl) begin
            m_disc = 1'b1;
         end
         if (fl) m_valid = 1'b0;
         #1;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      pool[0] = 32'h8000_0000;
      pool[1] = 32'h8000_0004;
      pool[2] = 32'h8000_0010;
      pool[3] = 32'h8000_0100;
      pool[4] = 32'h8000_0204;
      pool[5] = 32'h8000_0002;
      pool[6] = 32'h8000_0013;
      reset = 1'b1;
      drive(32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      test_reset();
      test_fill();
      test_hold();
      test_misaligned();
      test_bus_error();
      test_redirect();
      test_flush();
      test_reset_mid_req();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
